// File: rtl/fc_argmax_classifier.sv
`timescale 1ns/1ps
// fc_argmax_classifier
//
// Final stage of the CNN inference pipeline. Captures the NUM_CLASSES signed
// scores of the fully-connected layer on a rising edge of fc_valid_in, then
// scans them with one signed comparison per cycle. The winning class index
// and its score are offered downstream with a valid/ready handshake.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   fc_valid_in   FC layer all-neurons-valid (level)
//   fc_scores_in  NUM_CLASSES packed signed scores, class i at [i*DATA_W +: DATA_W]
//   class_idx     index of the maximum score
//   class_score   maximum score (signed, DATA_W bits)
//   class_valid   result valid
//   class_ready   downstream accepts result (only looked at while holding a result)
//   busy          high whenever the block is not idle
//   overrun       sticky: a frame was dropped because the block was busy
module fc_argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_W      = 54,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fc_valid_in,
    input  logic [NUM_CLASSES*DATA_W-1:0] fc_scores_in,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             class_score,
    output logic                          class_valid,
    input  logic                          class_ready,
    output logic                          busy,
    output logic                          overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]               state_q, state_d;
    logic                     fc_valid_q;
    logic signed [DATA_W-1:0] score_buf_q [NUM_CLASSES];
    logic                     buf_load;
    logic [IDX_W-1:0]         scan_cnt_q, scan_cnt_d;
    logic signed [DATA_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         class_idx_q, class_idx_d;
    logic [DATA_W-1:0]        class_score_q, class_score_d;
    logic                     class_valid_q, class_valid_d;
    logic                     overrun_q, overrun_d;

    logic                     frame_start;
    logic signed [DATA_W-1:0] cand;
    logic                     cand_wins;

    // A level that is already high when reset releases still counts as a new
    // frame, because fc_valid_q resets to 0.
    assign frame_start = fc_valid_in & ~fc_valid_q;

    assign cand      = score_buf_q[scan_cnt_q];
    // Strict compare: on a tie the earlier (lower) index is kept.
    assign cand_wins = cand > best_score_q;

    always_comb begin
        state_d       = state_q;
        buf_load      = 1'b0;
        scan_cnt_d    = scan_cnt_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        class_valid_d = class_valid_q;
        // Frames arriving while busy are dropped, never queued.
        overrun_d     = overrun_q | (frame_start & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    buf_load     = 1'b1;
                    best_score_d = fc_scores_in[DATA_W-1:0];
                    best_idx_d   = '0;
                    scan_cnt_d   = IDX_W'(1);
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cand_wins) begin
                    best_score_d = cand;
                    best_idx_d   = scan_cnt_q;
                end
                if (scan_cnt_q == LAST_IDX) begin
                    // Publish the final best including this cycle's comparison.
                    class_idx_d   = cand_wins ? scan_cnt_q : best_idx_q;
                    class_score_d = cand_wins ? cand : best_score_q;
                    class_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (class_ready) begin
                    class_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fc_valid_q    <= 1'b0;
            scan_cnt_q    <= '0;
            best_score_q  <= '0;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            class_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fc_valid_q    <= fc_valid_in;
            scan_cnt_q    <= scan_cnt_d;
            best_score_q  <= best_score_d;
            best_idx_q    <= best_idx_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            class_valid_q <= class_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Score buffer: written only on the capture edge so later input changes
    // cannot disturb a scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                score_buf_q[i] <= '0;
            end
        end else if (buf_load) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                score_buf_q[i] <= fc_scores_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign class_valid = class_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
`timescale 1ns/1ps
module tb_fc_argmax_classifier;

    localparam int NC = 10;
    localparam int DW = 54;
    localparam int IW = 4;

    logic              clk;
    logic              rst_n;
    logic              fc_valid_in;
    logic [NC*DW-1:0]  fc_scores_in;
    logic [IW-1:0]     class_idx;
    logic [DW-1:0]     class_score;
    logic              class_valid;
    logic              class_ready;
    logic              busy;
    logic              overrun;

    logic signed [DW-1:0] sc [NC];

    int errors = 0;
    int checks = 0;

    fc_argmax_classifier #(
        .NUM_CLASSES (NC),
        .DATA_W      (DW),
        .IDX_W       (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fc_valid_in  (fc_valid_in),
        .fc_scores_in (fc_scores_in),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .class_valid  (class_valid),
        .class_ready  (class_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fc_scores_in = '0;
        for (int i = 0; i < NC; i++) fc_scores_in[i*DW +: DW] = sc[i];
    end

    task automatic set_basic();
        sc[0] = 5;  sc[1] = -3;  sc[2] = 12;   sc[3] = 0;  sc[4] = 7;
        sc[5] = 1;  sc[6] = 2;   sc[7] = 40;   sc[8] = -100; sc[9] = 39;
    endtask

    task automatic set_tie();
        for (int i = 0; i < NC; i++) sc[i] = 0;
        sc[3] = 25;
        sc[6] = 25;
    endtask

    // Drive a one-cycle fc_valid_in pulse; returns just after the capture edge.
    task automatic start_frame();
        fc_valid_in = 1'b1;
        @(posedge clk); #1;
        fc_valid_in = 1'b0;
    endtask

    // Count edges after the capture edge until class_valid; bounded.
    task automatic wait_valid(output int lat);
        lat = 51;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (class_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [IW-1:0] exp_idx, input logic [DW-1:0] exp_score);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (class_idx !== exp_idx) begin
            errors++;
            $display("FAIL %s class_idx: got %0d expected %0d", name, class_idx, exp_idx);
        end
        checks++;
        if (class_score !== exp_score) begin
            errors++;
            $display("FAIL %s class_score: got %0h expected %0h", name, class_score, exp_score);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fc_valid_in = 1'b0;
        class_ready = 1'b1;
        set_basic();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({class_idx, class_score, class_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset outputs: idx=%0d score=%0h valid=%b busy=%b overrun=%b expected all 0",
                     class_idx, class_score, class_valid, busy, overrun);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle after release: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        class_ready = 1'b1;
        set_basic();
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic busy after capture: got %b expected 1", busy);
        end
        wait_valid(lat);
        check_result("basic", lat, 9, 4'd7, 54'd40);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic overrun: got %b expected 0", overrun);
        end
        @(posedge clk); #1;
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic single-cycle valid: valid=%b busy=%b expected 0 0", class_valid, busy);
        end
    endtask

    task automatic test_tie();
        int lat;
        set_tie();
        start_frame();
        wait_valid(lat);
        check_result("tie", lat, 9, 4'd3, 54'd25);
        @(posedge clk); #1;
    endtask

    task automatic test_negative();
        int lat;
        logic [DW-1:0] exp_s;
        sc[0] = {1'b1, {(DW-1){1'b0}}};
        for (int i = 1; i < NC - 1; i++) sc[i] = -50 * i;
        sc[9] = -1;
        exp_s = {DW{1'b1}};
        start_frame();
        wait_valid(lat);
        check_result("negative", lat, 9, 4'd9, exp_s);
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        class_ready = 1'b0;
        set_basic();
        start_frame();
        wait_valid(lat);
        check_result("hold", lat, 9, 4'd7, 54'd40);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (class_valid !== 1'b1 || class_idx !== 4'd7 || class_score !== 54'd40) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold stability: %0d unstable cycles, expected 0", bad);
        end
        class_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold release: valid=%b busy=%b expected 0 0", class_valid, busy);
        end
        checks++;
        if (class_idx !== 4'd7 || class_score !== 54'd40) begin
            errors++;
            $display("FAIL hold retain: idx=%0d score=%0h expected 7 28", class_idx, class_score);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        class_ready = 1'b1;
        set_basic();
        start_frame();
        wait_valid(lat);
        check_result("b2b first", lat, 9, 4'd7, 54'd40);
        set_tie();
        @(posedge clk); #1;
        start_frame();
        wait_valid(lat);
        check_result("b2b second", lat, 9, 4'd3, 54'd25);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b overrun: got %b expected 0", overrun);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overrun();
        int lat;
        int pulses;
        class_ready = 1'b1;
        set_basic();
        start_frame();
        // Scores change after capture; must not affect the result.
        for (int i = 0; i < NC; i++) sc[i] = 1000;
        repeat (3) @(posedge clk);
        #1;
        start_frame();
        wait_valid(lat);
        check_result("overrun first", lat, 5, 4'd7, 54'd40);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun set: got %b expected 1", overrun);
        end
        @(posedge clk); #1;
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun dropped frame ran: valid=%b busy=%b expected 0 0",
                     class_valid, busy);
        end
        // Level held high for 15 cycles: exactly one frame.
        pulses = 0;
        fc_valid_in = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (class_valid === 1'b1) pulses++;
        end
        fc_valid_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (class_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL held-level results: got %0d expected 1", pulses);
        end
        checks++;
        if (class_idx !== 4'd0 || class_score !== 54'd1000) begin
            errors++;
            $display("FAIL held-level result: idx=%0d score=%0d expected 0 1000",
                     class_idx, class_score);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun sticky: got %b expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        class_ready = 1'b1;
        set_basic();
        start_frame();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({class_idx, class_score, class_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL mid-scan reset: idx=%0d score=%0h valid=%b busy=%b overrun=%b expected all 0",
                     class_idx, class_score, class_valid, busy, overrun);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (class_valid === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL post-reset activity: got %0d active cycles expected 0", pulses);
        end
        set_tie();
        start_frame();
        wait_valid(lat);
        check_result("after reset", lat, 9, 4'd3, 54'd25);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_negative();
        test_hold();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
